// File: rtl/mul_accumulate_stage_pkg.sv
// Shared ALU definitions: default datapath width, accumulator FSM states,
// and the counter-width helper used by the accumulate stage.
// Pure declarations, no logic.
package mul_accumulate_stage_pkg;

  // Default multiplier/ALU operand width, shared by the multiplier and this stage.
  localparam int ALU_W = 7;

  // ACCUM: collecting products. HOLD: result presented, waiting for the consumer.
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_e;

  // Width of a counter that indexes 0..len-1, never narrower than one bit.
  function automatic int cnt_width(input int len);
    return (len <= 1) ? 1 : $clog2(len);
  endfunction

endpackage

// File: rtl/mul_accumulate_stage.sv
// Sums LEN consecutive multiplier products into an ACC_W-bit result with sticky error flags.
// Latency: result valid 1 cycle after the LEN-th accepted product; at least one bubble between results.
// Backpressure: in_ready drops while a result is held or clr is asserted; result held until out_ready.
module mul_accumulate_stage
  import mul_accumulate_stage_pkg::*;
#(
  parameter int N     = ALU_W,
  parameter int ACC_W = 10,
  parameter int LEN   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in_product,
  input  logic             in_cout,
  input  logic             in_overflow,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clr,
  output logic [ACC_W-1:0] out,
  output logic             mul_err,
  output logic             acc_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int               CNT_W    = cnt_width(LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

  acc_state_e       state_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] out_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mul_err_q;
  logic             acc_ovf_q;
  logic             out_valid_q;

  logic             accept;
  logic [ACC_W:0]   sum_d;
  logic             mul_err_d;
  logic             acc_ovf_d;

  // clr blocks acceptance in the same cycle so a product is never half-counted.
  assign in_ready  = (state_q == ACCUM) && !clr;
  assign accept    = in_valid && in_ready;

  // One extra bit on the adder captures the carry out of the accumulator.
  assign sum_d     = {1'b0, acc_q} + {{(ACC_W + 1 - N){1'b0}}, in_product};
  assign mul_err_d = mul_err_q | in_cout | in_overflow;
  assign acc_ovf_d = acc_ovf_q | sum_d[ACC_W];

  assign out       = out_q;
  assign mul_err   = mul_err_q;
  assign acc_ovf   = acc_ovf_q;
  assign out_valid = out_valid_q;

  // Accumulate/hold FSM; clr overrides both states, out keeps its last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      out_q       <= '0;
      cnt_q       <= '0;
      mul_err_q   <= 1'b0;
      acc_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (clr) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      mul_err_q   <= 1'b0;
      acc_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            acc_q     <= sum_d[ACC_W-1:0];
            mul_err_q <= mul_err_d;
            acc_ovf_q <= acc_ovf_d;
            if (cnt_q == CNT_LAST) begin
              state_q     <= HOLD;
              out_q       <= sum_d[ACC_W-1:0];
              out_valid_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            mul_err_q   <= 1'b0;
            acc_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_accumulate_stage.sv
// Self-checking bench: directed scenarios plus randomized traffic against a sum-based model.
// Three instances: default (ACC_W=10, LEN=4), narrow accumulator (ACC_W=8), single-product (LEN=1).
// Inputs driven and outputs sampled on the falling edge.
module tb_mul_accumulate_stage;

  localparam int A_W   = 10;
  localparam int A_LEN = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Instance A: defaults
  logic [6:0] a_in_product = '0;
  logic       a_in_cout = 1'b0, a_in_overflow = 1'b0, a_in_valid = 1'b0, a_clr = 1'b0, a_out_ready = 1'b0;
  logic       a_in_ready, a_mul_err, a_acc_ovf, a_out_valid;
  logic [9:0] a_out;

  // Instance B: 8-bit accumulator
  logic [6:0] b_in_product = '0;
  logic       b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic       b_in_ready, b_mul_err, b_acc_ovf, b_out_valid;
  logic [7:0] b_out;

  // Instance C: LEN=1
  logic [6:0] c_in_product = '0;
  logic       c_in_valid = 1'b0, c_out_ready = 1'b0;
  logic       c_in_ready, c_mul_err, c_acc_ovf, c_out_valid;
  logic [9:0] c_out;

  mul_accumulate_stage #(.N(7), .ACC_W(10), .LEN(4)) u_a (
    .clk(clk), .rst_n(rst_n), .in_product(a_in_product), .in_cout(a_in_cout),
    .in_overflow(a_in_overflow), .in_valid(a_in_valid), .in_ready(a_in_ready), .clr(a_clr),
    .out(a_out), .mul_err(a_mul_err), .acc_ovf(a_acc_ovf), .out_valid(a_out_valid),
    .out_ready(a_out_ready)
  );

  mul_accumulate_stage #(.N(7), .ACC_W(8), .LEN(4)) u_b (
    .clk(clk), .rst_n(rst_n), .in_product(b_in_product), .in_cout(1'b0),
    .in_overflow(1'b0), .in_valid(b_in_valid), .in_ready(b_in_ready), .clr(1'b0),
    .out(b_out), .mul_err(b_mul_err), .acc_ovf(b_acc_ovf), .out_valid(b_out_valid),
    .out_ready(b_out_ready)
  );

  mul_accumulate_stage #(.N(7), .ACC_W(10), .LEN(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_product(c_in_product), .in_cout(1'b0),
    .in_overflow(1'b0), .in_valid(c_in_valid), .in_ready(c_in_ready), .clr(1'b0),
    .out(c_out), .mul_err(c_mul_err), .acc_ovf(c_acc_ovf), .out_valid(c_out_valid),
    .out_ready(c_out_ready)
  );

  // Reference model for instance A: running integer total of the current group.
  bit m_hold  = 1'b0;
  int m_cnt   = 0;
  int m_total = 0;
  bit m_err   = 1'b0;
  int m_out   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    m_hold = 1'b0; m_cnt = 0; m_total = 0; m_err = 1'b0; m_out = 0;
  endtask

  // One clock of instance A, starting and ending on a falling edge.
  task automatic a_cycle(input bit v, input int prod, input bit co, input bit ov,
                         input bit cl, input bit ordy);
    a_in_valid = v; a_in_product = prod[6:0]; a_in_cout = co; a_in_overflow = ov;
    a_clr = cl; a_out_ready = ordy;
    #1;
    check("a_in_ready", int'(a_in_ready), int'(!m_hold && !cl));
    if (cl) begin
      m_hold = 1'b0; m_cnt = 0; m_total = 0; m_err = 1'b0;
    end else if (m_hold) begin
      if (ordy) begin
        m_hold = 1'b0; m_cnt = 0; m_total = 0; m_err = 1'b0;
      end
    end else if (v) begin
      m_total += prod;
      m_err |= co | ov;
      m_cnt++;
      if (m_cnt == A_LEN) begin
        m_hold = 1'b1;
        m_out  = m_total % (1 << A_W);
      end
    end
    @(negedge clk);
    a_in_valid = 1'b0; a_clr = 1'b0; a_out_ready = 1'b0; a_in_cout = 1'b0; a_in_overflow = 1'b0;
    check("a_out_valid", int'(a_out_valid), int'(m_hold));
    check("a_out", int'(a_out), m_out);
    check("a_mul_err", int'(a_mul_err), int'(m_err));
    check("a_acc_ovf", int'(a_acc_ovf), int'(m_total >= (1 << A_W)));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_a_out_valid", int'(a_out_valid), 0);
    check("rst_a_out", int'(a_out), 0);
    check("rst_a_flags", int'({a_mul_err, a_acc_ovf}), 0);
    check("rst_a_in_ready", int'(a_in_ready), 1);
    check("rst_c_in_ready", int'(c_in_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Products 1,1,12,97 with overflow flagged on the last one.
    a_cycle(1, 1, 0, 0, 0, 0);
    a_cycle(1, 1, 0, 0, 0, 0);
    a_cycle(1, 12, 0, 0, 0, 0);
    check("t1_pre_valid", int'(a_out_valid), 0);
    a_cycle(1, 97, 0, 1, 0, 0);
    check("t1_out", int'(a_out), 111);
    check("t1_mul_err", int'(a_mul_err), 1);
    check("t1_acc_ovf", int'(a_acc_ovf), 0);
    check("t1_valid_lat1", int'(a_out_valid), 1);

    // Consumer stalls for 5 cycles while products are offered.
    for (int i = 0; i < 5; i++) a_cycle(i[0], 50, 1, 0, 0, 0);
    check("t2_held_out", int'(a_out), 111);
    check("t2_held_err", int'(a_mul_err), 1);
    a_cycle(0, 0, 0, 0, 0, 1);
    check("t2_valid_drop", int'(a_out_valid), 0);
    check("t2_ready_back", int'(a_in_ready), 1);
    check("t2_out_kept", int'(a_out), 111);

    // clr discards a partial sum and blocks the product offered with it.
    a_cycle(1, 5, 0, 0, 0, 0);
    a_cycle(1, 6, 1, 0, 0, 0);
    a_cycle(1, 9, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) a_cycle(1, 2, 0, 0, 0, 0);
    check("t4_out", int'(a_out), 8);
    check("t4_flags", int'({a_mul_err, a_acc_ovf}), 0);

    // clr while holding a result overrides out_ready.
    a_cycle(0, 0, 0, 0, 1, 1);
    check("t4_clr_hold", int'(a_out_valid), 0);

    // Async reset while in HOLD.
    for (int i = 0; i < 4; i++) a_cycle(1, 7, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", int'(a_out_valid), 0);
    check("t6_rst_out", int'(a_out), 0);
    check("t6_rst_flags", int'({a_mul_err, a_acc_ovf}), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) a_cycle(1, i, 0, 0, 0, 0);
    check("t6_out", int'(a_out), 10);
    a_cycle(0, 0, 0, 0, 0, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      a_cycle(bit'($urandom_range(0, 1)), int'($urandom_range(0, 127)),
              bit'($urandom_range(0, 7) == 0), bit'($urandom_range(0, 7) == 0),
              bit'($urandom_range(0, 19) == 0), bit'($urandom_range(0, 1)));
    end

    // Instance B: four products of 127 wrap the 8-bit accumulator.
    b_in_valid = 1'b1; b_in_product = 7'd127;
    for (int i = 0; i < 4; i++) begin
      #1 check("b_in_ready", int'(b_in_ready), 1);
      @(negedge clk);
    end
    b_in_valid = 1'b0;
    check("b_out_valid", int'(b_out_valid), 1);
    check("b_out", int'(b_out), 252);
    check("b_acc_ovf", int'(b_acc_ovf), 1);
    check("b_mul_err", int'(b_mul_err), 0);

    // Instance C: LEN=1, products 3 then 12 with out_ready tied high.
    c_out_ready = 1'b1;
    c_in_valid = 1'b1; c_in_product = 7'd3;
    #1 check("c_rdy0", int'(c_in_ready), 1);
    @(negedge clk);
    c_in_product = 7'd12;
    check("c_res0_valid", int'(c_out_valid), 1);
    check("c_res0", int'(c_out), 3);
    check("c_rdy_hold", int'(c_in_ready), 0);
    @(negedge clk);
    check("c_bubble", int'(c_out_valid), 0);
    check("c_rdy1", int'(c_in_ready), 1);
    @(negedge clk);
    c_in_valid = 1'b0;
    check("c_res1_valid", int'(c_out_valid), 1);
    check("c_res1", int'(c_out), 12);
    @(negedge clk);
    check("c_idle", int'(c_out_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
